// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: hex or decimal (double-dabble)
// display of a loaded value with leading-zero blanking and overflow dashes.
module seg7_display_ctrl #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    LOAD,
  input  logic [DATA_W-1:0]       DATA,
  input  logic                    MODE,
  input  logic                    BLANK,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    OVF,
  output logic [8*NUM_DIGITS-1:0] HEX
);

  // ceil(DATA_W*log10(2)) decimal digits hold any DATA_W-bit value
  localparam int BCD_DIGITS = (DATA_W * 30103 + 99999) / 100000;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int SRC_W      = 4 * NUM_DIGITS + BCD_W + DATA_W;
  localparam int HEX_W      = 8 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               mode_q, mode_d;
  logic               blank_q, blank_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [HEX_W-1:0]   hex_q, hex_d;

  logic [BCD_W-1:0]   adj;
  logic [SRC_W-1:0]   src;
  logic [3:0]         nib;
  logic               seen;
  logic               ovf_c;
  logic [HEX_W-1:0]   dec_hex;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    unique case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      4'hF: return 8'h8E;
    endcase
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Digit decode: overflow dashes, leading-zero blanking, glyph lookup.
  // BCD is exact, so in both modes overflow means a nonzero nibble above
  // the displayed digits.
  always_comb begin
    src     = mode_q ? SRC_W'(bcd_q) : SRC_W'(data_q);
    ovf_c   = (src >> (4 * NUM_DIGITS)) != '0;
    seen    = 1'b0;
    nib     = 4'd0;
    dec_hex = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = src[4*i +: 4];
      if (nib != 4'd0 || i == 0)
        seen = 1'b1;
      if (ovf_c)
        dec_hex[8*i +: 8] = 8'hBF;
      else if (blank_q && !seen)
        dec_hex[8*i +: 8] = 8'hFF;
      else
        dec_hex[8*i +: 8] = glyph(nib);
    end
  end

  // Control FSM: capture request, shift-convert, commit to display
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    unique case (state_q)
      IDLE: begin
        if (req_q) begin
          req_d  = 1'b0;
          busy_d = 1'b1;
          if (mode_q) begin
            bcd_d   = '0;
            cnt_d   = CNT_W'(DATA_W);
            state_d = SHIFT;
          end else begin
            state_d = COMMIT;
          end
        end else if (LOAD) begin
          req_d   = 1'b1;
          data_d  = DATA;
          mode_d  = MODE;
          blank_d = BLANK;
        end
      end
      SHIFT: begin
        bcd_d  = {adj[BCD_W-2:0], data_q[DATA_W-1]};
        data_d = {data_q[DATA_W-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_d = COMMIT;
      end
      COMMIT: begin
        hex_d   = dec_hex;
        ovf_d   = ovf_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset blanks the display
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      blank_q <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hex_q   <= '1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OVF  = ovf_q;
  assign HEX  = hex_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: 5-digit and 4-digit instances on shared
// stimulus, checked against an arithmetic digit/glyph model.
module tb_seg7_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic        mode;
  logic        blank;
  logic        busy5, done5, ovf5;
  logic        busy4, done4, ovf4;
  logic [39:0] hex5;
  logic [31:0] hex4;

  int n_assert = 0;
  int n_fail   = 0;

  logic [39:0] prev5;
  logic [31:0] prev4;
  logic [15:0] cur_v;
  bit          cur_dec;
  bit          cur_blk;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  always #10 clk = ~clk;

  seg7_display_ctrl #(.DATA_W(16), .NUM_DIGITS(5)) dut5 (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .LOAD     (load),
    .DATA     (data),
    .MODE     (mode),
    .BLANK    (blank),
    .BUSY     (busy5),
    .DONE     (done5),
    .OVF      (ovf5),
    .HEX      (hex5)
  );

  seg7_display_ctrl #(.DATA_W(16), .NUM_DIGITS(4)) dut4 (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .LOAD     (load),
    .DATA     (data),
    .MODE     (mode),
    .BLANK    (blank),
    .BUSY     (busy4),
    .DONE     (done4),
    .OVF      (ovf4),
    .HEX      (hex4)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ovf(input int unsigned v, input bit dec,
                                   input int nd);
    longint unsigned lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * (dec ? 10 : 16);
    return longint'(v) >= lim;
  endfunction

  function automatic logic [39:0] model_hex(input int unsigned v,
                                            input bit dec, input bit blk,
                                            input int nd);
    longint unsigned base = dec ? 10 : 16;
    longint unsigned vv = v;
    longint unsigned p = 1;
    int d [5];
    int msd = 0;
    logic [39:0] r = '1;
    for (int i = 0; i < nd; i++) begin
      d[i] = int'((vv / p) % base);
      if (d[i] != 0) msd = i;
      p = p * base;
    end
    for (int i = 0; i < nd; i++) begin
      if (model_ovf(v, dec, nd)) r[8*i +: 8] = 8'hBF;
      else if (blk && i > msd)   r[8*i +: 8] = 8'hFF;
      else                       r[8*i +: 8] = GLYPH[d[i]];
    end
    return r;
  endfunction

  // Present a request for one edge; caller sits at a negedge.
  task automatic launch(input logic [15:0] v, input bit dec, input bit blk);
    load = 1'b1; data = v; mode = dec; blank = blk;
    cur_v = v; cur_dec = dec; cur_blk = blk;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Walk to the expected DONE edge, checking BUSY/DONE/hold on the way,
  // optionally injecting a LOAD of 5 while busy. Ends in the DONE cycle.
  task automatic await_done(input int inj_at);
    int lat = cur_dec ? 18 : 2;
    int bad_done = 0;
    int bad_busy = 0;
    int bad_hold = 0;
    logic [39:0] e5;
    logic [39:0] e4full;
    logic [31:0] e4;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done5 !== 1'(k == lat) || done4 !== 1'(k == lat)) bad_done++;
      if (busy5 !== 1'(k < lat) || busy4 !== 1'(k < lat)) bad_busy++;
      if (k < lat && (hex5 !== prev5 || hex4 !== prev4)) bad_hold++;
      if (k == inj_at) begin
        load = 1'b1; data = 16'd5; mode = 1'b1; blank = 1'b1;
      end else if (k == inj_at + 1) begin
        load = 1'b0;
      end
    end
    chk("done_timing", 64'(bad_done), 64'd0);
    chk("busy_timing", 64'(bad_busy), 64'd0);
    chk("hex_hold", 64'(bad_hold), 64'd0);
    e5     = model_hex(cur_v, cur_dec, cur_blk, 5);
    e4full = model_hex(cur_v, cur_dec, cur_blk, 4);
    e4     = e4full[31:0];
    chk("hex5", 64'(hex5), 64'(e5));
    chk("ovf5", 64'(ovf5), 64'(model_ovf(cur_v, cur_dec, 5)));
    chk("hex4", 64'(hex4), 64'(e4));
    chk("ovf4", 64'(ovf4), 64'(model_ovf(cur_v, cur_dec, 4)));
    prev5 = e5;
    prev4 = e4;
  endtask

  task automatic idle_no_done(input string tag, input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done5 !== 1'b0 || done4 !== 1'b0 || busy5 !== 1'b0) bad++;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [15:0] rv;
    bit rd;
    bit rb;
    rst = 1'b1; load = 1'b0; data = '0; mode = 1'b0; blank = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_hex5", 64'(hex5), 64'hFF_FFFF_FFFF);
    chk("reset_hex4", 64'(hex4), 64'hFFFF_FFFF);
    chk("reset_busy", 64'(busy5), 64'd0);
    chk("reset_done", 64'(done5), 64'd0);
    chk("reset_ovf", 64'(ovf5), 64'd0);
    prev5 = '1;
    prev4 = '1;

    launch(16'd1234, 1'b1, 1'b1);
    await_done(-1);
    chk("dec1234_const", 64'(hex5), 64'hFF_F9A4_B099);

    launch(16'hBEEF, 1'b0, 1'b0);
    await_done(-1);
    chk("hexBEEF_const", 64'(hex5), 64'hC0_8386_868E);

    launch(16'd9999, 1'b1, 1'b0);
    await_done(-1);
    chk("nd4_9999_const", 64'(hex4), 64'h9090_9090);
    chk("nd4_9999_ovf", 64'(ovf4), 64'd0);

    launch(16'd10000, 1'b1, 1'b0);
    await_done(-1);
    chk("nd4_10000_const", 64'(hex4), 64'hBFBF_BFBF);
    chk("nd4_10000_ovf", 64'(ovf4), 64'd1);

    launch(16'd1234, 1'b1, 1'b1);
    await_done(5);
    chk("reject_1234", 64'(hex5), 64'hFF_F9A4_B099);
    launch(16'd5, 1'b1, 1'b1);
    await_done(-1);
    chk("donecycle_load5", 64'(hex5), 64'hFF_FFFF_FF92);
    idle_no_done("post_idle", 3);

    launch(16'hFFFF, 1'b1, 1'b1);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("midrst_hex5", 64'(hex5), 64'hFF_FFFF_FFFF);
    chk("midrst_hex4", 64'(hex4), 64'hFFFF_FFFF);
    chk("midrst_busy", 64'(busy5), 64'd0);
    chk("midrst_ovf", 64'(ovf5), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_no_done("midrst_no_done", 25);
    prev5 = '1;
    prev4 = '1;
    launch(16'd4321, 1'b1, 1'b1);
    await_done(-1);

    launch(16'd0, 1'b1, 1'b1);
    await_done(-1);
    chk("zero_blank", 64'(hex5), 64'hFF_FFFF_FFC0);
    launch(16'd0, 1'b1, 1'b0);
    await_done(-1);
    chk("zero_noblank", 64'(hex5), 64'hC0_C0C0_C0C0);

    for (int t = 0; t < 12; t++) begin
      rv = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) rv = rv % 16'd1000;
      rd = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      launch(rv, rd, rb);
      await_done(-1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Parametrised multi-digit 7-segment display controller for the board HEX displays.
- Accepts a binary value through a load handshake and shows it on NUM_DIGITS displays in either hexadecimal or decimal.
- Decimal mode uses a sequential double-dabble binary-to-BCD converter.
- Adds leading-zero blanking and overflow indication.
- Segment outputs are registered and change atomically, so the displays never show partial results.

Parameters:
- DATA_W, 16, width of input value; legal range 4..32.
- NUM_DIGITS, 5, number of 7-segment digits driven; legal range 1..9.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- LOAD  in  1  request to capture DATA/MODE/BLANK; honoured only when BUSY=0
- DATA  in  DATA_W  unsigned value to display
- MODE  in  1  0 = hexadecimal, 1 = decimal
- BLANK  in  1  1 = blank leading zeros (digit 0 never blanked)
- BUSY  out  1  conversion in progress; LOAD ignored while high
- DONE  out  1  one-cycle pulse when HEX takes the new value
- OVF  out  1  last committed value did not fit in NUM_DIGITS
- HEX  out  8*NUM_DIGITS  packed, active-low; HEX[8i+6:8i] = segments g..a of digit i (digit 0 rightmost); HEX[8i+7] = decimal point, always 1 (off)

Behaviour:
- Reset (async, active-high):
  - HEX = all 1s (all segments off); BUSY=0, DONE=0, OVF=0; FSM=IDLE.
  - Reset mid-conversion abandons the conversion; no DONE pulse is issued.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - LOAD=1 at an edge captures DATA, MODE and BLANK.
  - MODE=1: BCD register is cleared, shift counter is set to DATA_W, next state is SHIFT.
  - MODE=0: next state is COMMIT directly.
  - BUSY goes high in the cycle after the capture edge.
- SHIFT, each cycle:
  - Every BCD nibble >= 5 gets +3.
  - The BCD register and data shift left one bit; data MSB enters BCD bit 0.
  - Counter decrements; after the DATA_W-th shift, next state is COMMIT.
- BCD register width: 4*ceil(DATA_W*log10(2)) bits, so the conversion itself never overflows.
- COMMIT:
  - Edge leaving COMMIT: HEX <= decoded digits, DONE <= 1 for exactly one cycle, BUSY <= 0, OVF <= overflow flag; next state is IDLE.
- Latency (load edge = edge 0):
  - Hex mode: HEX changes and DONE is high after edge 2.
  - Decimal mode: HEX changes and DONE is high after edge DATA_W+2.
- LOAD while BUSY=1 is ignored entirely (not queued).
- LOAD=1 in the same cycle DONE is high is accepted, since BUSY=0 then.
- Hex mode digit values:
  - Digit i = DATA[4i+3:4i]; bits beyond DATA_W read as 0.
  - Overflow when DATA has a nonzero bit at position >= 4*NUM_DIGITS.
- Decimal mode digit values:
  - Digit i = BCD nibble i.
  - Overflow when the captured value >= 10^NUM_DIGITS.
- Overflow display: all digits show dash (g only; 8-bit field = 0xBF); BLANK is ignored.
- Blanking (BLANK=1): digits above the most significant nonzero digit are all-1s (0xFF); digit 0 is always displayed (value 0 shows "0").
- Glyph table, 8-bit field with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- HEX, DONE and OVF are driven only from registers; no combinational path from any input to any output.

Test Plan:
- After reset: HEX=all 0xFF, BUSY=0, DONE=0. Then LOAD DATA=16'd1234, MODE=1, BLANK=1 for one cycle:
  - BUSY=1 for 17 cycles.
  - DONE pulses once after edge 18.
  - HEX digits 4..0 = FF,F9,A4,B0,99; OVF=0.
- DATA=16'hBEEF, MODE=0, BLANK=0:
  - DONE after edge 2.
  - Digits 4..0 = C0,83,86,86,8E.
- NUM_DIGITS=4, MODE=1:
  - DATA=9999 gives 90,90,90,90 with OVF=0.
  - Then DATA=10000 gives BF,BF,BF,BF with OVF=1.
- Busy rejection: LOAD 1234 decimal, then pulse LOAD 5 at cycle 5 of SHIFT:
  - Only one DONE.
  - Display shows 1234.
  - A LOAD 5 in the DONE cycle is accepted and shows 5 after a further 18 edges.
- RESET asserted mid-SHIFT:
  - HEX goes immediately to all 0xFF, BUSY=0.
  - No DONE pulse follows.
  - The next LOAD converts normally.
- Value 0, MODE=1, BLANK=1 gives digits FF,FF,FF,FF,C0; the same value with BLANK=0 gives all C0.
